// File: rtl/axil_led_irq_ctrl_if.sv
// AXI4-Lite channel bundle between the XDMA m_axil master and the LED/IRQ register block.
interface axil_led_irq_ctrl_if #(
    parameter int ADDR_WIDTH = 9
) ();
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_led_irq_ctrl.sv
// AXI4-Lite LED bank (static + optional blink) and XDMA user-interrupt generator.
// Define AXIL_LED_BLINK_EN to build the blink counter with BLINK_MASK/BLINK_PERIOD.
module axil_led_irq_ctrl #(
    parameter int WIRQ       = 2,
    parameter int ADDR_WIDTH = 9,
    parameter int CNT_WIDTH  = 32
) (
    input  logic               axi_aclk,
    input  logic               axi_aresetn,
    axil_led_irq_ctrl_if.slave s_axil,
    output logic [7:0]         led,
    output logic [WIRQ-1:0]    usr_irq_req,
    input  logic [WIRQ-1:0]    usr_irq_ack
);
    localparam logic [2:0] A_LED    = 3'd0;
    localparam logic [2:0] A_MASK   = 3'd1;
    localparam logic [2:0] A_PERIOD = 3'd2;
    localparam logic [2:0] A_TRIG   = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;
    localparam logic [2:0] A_COUNT  = 3'd5;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {IRQ_IDLE = 1'b0, IRQ_REQ = 1'b1} irq_state_e;

    logic        rdy_q, aw_got_q, w_got_q, bvalid_q, rvalid_q;
    logic [2:0]  awidx_q;
    logic [31:0] wdata_q, rdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  bresp_q, rresp_q;
    logic        aw_hs, w_hs, ar_hs, wr_fire;
    logic [2:0]  wr_idx;
    logic [31:0] wr_data, strb_bits, rd_word;
    logic [3:0]  wr_strb;
    logic [1:0]  rd_resp;
    logic [7:0]  led_out_q, led_out_d;
    logic [31:0] irq_cnt_q, irq_cnt_d;
    logic [WIRQ-1:0] trig, pend_vec;
    logic        unused_bits;

    // Ready is held low for the first cycle after reset release via rdy_q.
    assign s_axil.awready = rdy_q & ~aw_got_q & ~bvalid_q;
    assign s_axil.wready  = rdy_q & ~w_got_q & ~bvalid_q;
    assign s_axil.arready = rdy_q & ~rvalid_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rdata   = rdata_q;
    assign s_axil.rresp   = rresp_q;

    assign aw_hs     = s_axil.awvalid & s_axil.awready;
    assign w_hs      = s_axil.wvalid & s_axil.wready;
    assign ar_hs     = s_axil.arvalid & s_axil.arready;
    assign wr_fire   = (aw_got_q | aw_hs) & (w_got_q | w_hs);
    assign wr_idx    = aw_got_q ? awidx_q : s_axil.awaddr[4:2];
    assign wr_data   = w_got_q ? wdata_q : s_axil.wdata;
    assign wr_strb   = w_got_q ? wstrb_q : s_axil.wstrb;
    assign strb_bits = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
    assign unused_bits = ^{s_axil.awaddr, s_axil.araddr, wr_data, strb_bits};

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rdy_q    <= 1'b0;
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            awidx_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rdy_q <= 1'b1;
            if (wr_fire) begin
                aw_got_q <= 1'b0;
                w_got_q  <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= (wr_idx > A_COUNT) ? RESP_SLVERR : RESP_OKAY;
            end else begin
                if (aw_hs) begin
                    aw_got_q <= 1'b1;
                    awidx_q  <= s_axil.awaddr[4:2];
                end
                if (w_hs) begin
                    w_got_q <= 1'b1;
                    wdata_q <= s_axil.wdata;
                    wstrb_q <= s_axil.wstrb;
                end
                if (bvalid_q && s_axil.bready) bvalid_q <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_word;
                rresp_q  <= rd_resp;
            end else if (rvalid_q && s_axil.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

`ifdef AXIL_LED_BLINK_EN
    logic [7:0]           blink_mask_q, blink_mask_d;
    logic [CNT_WIDTH-1:0] period_q, period_d, cnt_q, cnt_d;
    logic                 phase_q, phase_d;

    always_comb begin
        blink_mask_d = blink_mask_q;
        period_d     = period_q;
        cnt_d        = cnt_q;
        phase_d      = phase_q;
        if (wr_fire && wr_idx == A_MASK && wr_strb[0]) blink_mask_d = wr_data[7:0];
        if (wr_fire && wr_idx == A_PERIOD) begin
            period_d = (period_q & ~strb_bits[CNT_WIDTH-1:0]) |
                       (wr_data[CNT_WIDTH-1:0] & strb_bits[CNT_WIDTH-1:0]);
            cnt_d    = '0;
            phase_d  = 1'b0;
        end else if (period_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == period_q - CNT_WIDTH'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            blink_mask_q <= '0;
            period_q     <= '0;
            cnt_q        <= '0;
            phase_q      <= 1'b0;
        end else begin
            blink_mask_q <= blink_mask_d;
            period_q     <= period_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
        end
    end

    assign led = led_out_q ^ (blink_mask_q & {8{phase_q}});
`else
    assign led = led_out_q;
`endif

    always_comb begin
        rd_word = '0;
        rd_resp = RESP_OKAY;
        case (s_axil.araddr[4:2])
            A_LED:    rd_word[7:0] = led_out_q;
`ifdef AXIL_LED_BLINK_EN
            A_MASK:   rd_word[7:0] = blink_mask_q;
            A_PERIOD: rd_word[CNT_WIDTH-1:0] = period_q;
`endif
            A_STATUS: begin
                rd_word[16 +: WIRQ]  = pend_vec;
                rd_word[WIRQ-1:0]    = usr_irq_req;
            end
            A_COUNT:  rd_word = irq_cnt_q;
            3'd6, 3'd7: rd_resp = RESP_SLVERR;
            default:  rd_word = '0;
        endcase
    end

    assign led_out_d = (wr_fire && wr_idx == A_LED && wr_strb[0]) ? wr_data[7:0] : led_out_q;
    assign trig      = (wr_fire && wr_idx == A_TRIG) ?
                       (wr_data[WIRQ-1:0] & strb_bits[WIRQ-1:0]) : '0;
    // Only acks landing on a requesting line are counted; idle-line acks are ignored.
    assign irq_cnt_d = irq_cnt_q + 32'($countones(usr_irq_ack & usr_irq_req));

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            led_out_q <= '0;
            irq_cnt_q <= '0;
        end else begin
            led_out_q <= led_out_d;
            irq_cnt_q <= irq_cnt_d;
        end
    end

    for (genvar g = 0; g < WIRQ; g++) begin : g_irq
        irq_state_e st_q, st_d;
        logic       pend_q, pend_d;

        always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
            if (!axi_aresetn) begin
                st_q   <= IRQ_IDLE;
                pend_q <= 1'b0;
            end else begin
                st_q   <= st_d;
                pend_q <= pend_d;
            end
        end

        always_comb begin
            st_d   = st_q;
            pend_d = pend_q | trig[g];
            case (st_q)
                IRQ_IDLE: if (pend_q) begin
                    st_d   = IRQ_REQ;
                    pend_d = trig[g];
                end
                IRQ_REQ:  if (usr_irq_ack[g]) st_d = IRQ_IDLE;
                default:  st_d = IRQ_IDLE;
            endcase
        end

        assign usr_irq_req[g] = (st_q == IRQ_REQ);
        assign pend_vec[g]    = pend_q;
    end
endmodule

// File: tb/tb_axil_led_irq_ctrl.sv
// Randomized self-checking bench for axil_led_irq_ctrl against a register/interrupt reference model.
`timescale 1ns/1ps
module tb_axil_led_irq_ctrl;
    localparam int WIRQ = 2;
    localparam int AW   = 9;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      led;
    logic [WIRQ-1:0] req;
    logic [WIRQ-1:0] ack;
    int              checks = 0;
    int              errors = 0;

    logic [7:0]      m_led_out;
    logic [31:0]     m_cnt;
    logic [WIRQ-1:0] m_req, m_pend;

    axil_led_irq_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    axil_led_irq_ctrl #(.WIRQ(WIRQ), .ADDR_WIDTH(AW), .CNT_WIDTH(32)) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n), .s_axil(bus),
        .led(led), .usr_irq_req(req), .usr_irq_ack(ack)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic bv, output logic [WIRQ-1:0] req_b);
        int n;
        logic aw_done, w_done, awf, wf;
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            awf = bus.awvalid & bus.awready;
            wf  = bus.wvalid & bus.wready;
            tick(); n++;
            if (awf) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
            if (wf)  begin w_done  = 1'b1; bus.wvalid  = 1'b0; end
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bv = bus.bvalid & aw_done & w_done;
        resp = bus.bresp;
        req_b = req;
        if (bv) begin
            bus.bready = 1'b1; tick(); bus.bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [8:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output logic rv);
        int n;
        logic done, arf;
        bus.araddr = addr; bus.arvalid = 1'b1;
        done = 1'b0; n = 0;
        while (!done && n < 20) begin
            arf = bus.arvalid & bus.arready;
            tick(); n++;
            if (arf) begin done = 1'b1; bus.arvalid = 1'b0; end
        end
        bus.arvalid = 1'b0;
        rv = done & bus.rvalid;
        data = bus.rdata;
        resp = bus.rresp;
        if (rv) begin
            bus.rready = 1'b1; tick(); bus.rready = 1'b0;
        end
    endtask

    // Model: a line with a queued trigger and no active request starts requesting.
    task automatic m_settle();
        for (int i = 0; i < WIRQ; i++)
            if (!m_req[i] && m_pend[i]) begin m_req[i] = 1'b1; m_pend[i] = 1'b0; end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL rst_led got %h exp 00", led); end
        checks++; if (req !== '0) begin errors++; $display("FAIL rst_req got %b exp 0", req); end
        checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin errors++;
            $display("FAIL rst_ready got %b exp 000", {bus.awready, bus.wready, bus.arready}); end
        checks++; if ({bus.bvalid, bus.rvalid, bus.bresp, bus.rresp} !== 6'b0) begin errors++;
            $display("FAIL rst_resp got %b exp 0", {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp}); end
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.rdata); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.awready !== 1'b0) begin errors++; $display("FAIL rel_awready got %b exp 0", bus.awready); end
        tick();
        checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin errors++;
            $display("FAIL post_rel_ready got %b exp 111", {bus.awready, bus.wready, bus.arready}); end
    endtask

    task automatic test_led_basic();
        logic [1:0] r; logic bv, rv; logic [WIRQ-1:0] rq; logic [31:0] d;
        axi_write(9'h00, 32'h000000A5, 4'hF, r, bv, rq);
        m_led_out = 8'hA5;
        checks++; if (bv !== 1'b1 || r !== 2'b00) begin errors++; $display("FAIL led_wr_resp got bv=%b resp=%b exp 1/00", bv, r); end
        checks++; if (led !== 8'hA5) begin errors++; $display("FAIL led_out got %h exp a5", led); end
        axi_read(9'h00, d, r, rv);
        checks++; if (rv !== 1'b1 || d !== 32'hA5 || r !== 2'b00) begin errors++;
            $display("FAIL led_rd got rv=%b d=%h r=%b exp 1/a5/00", rv, d, r); end
    endtask

    task automatic test_led_random();
        logic [1:0] r; logic bv, rv; logic [WIRQ-1:0] rq; logic [31:0] d, data; logic [3:0] strb;
        for (int it = 0; it < 8; it++) begin
            data = $urandom; strb = 4'($urandom_range(0, 15));
            axi_write(9'h00, data, strb, r, bv, rq);
            if (strb[0]) m_led_out = data[7:0];
            checks++; if (led !== m_led_out) begin errors++; $display("FAIL led_rand it%0d got %h exp %h", it, led, m_led_out); end
            axi_read(9'h00, d, r, rv);
            checks++; if (d !== {24'h0, m_led_out}) begin errors++; $display("FAIL led_rand_rd it%0d got %h exp %h", it, d, m_led_out); end
        end
    endtask

    task automatic test_aw_lead();
        logic [7:0] nv;
        nv = ~m_led_out;
        bus.awaddr = 9'h00; bus.awvalid = 1'b1; bus.wvalid = 1'b0;
        checks++; if (bus.awready !== 1'b1) begin errors++; $display("FAIL lead_awready got %b exp 1", bus.awready); end
        tick(); bus.awvalid = 1'b0;
        repeat (2) tick();
        checks++; if (led !== m_led_out || bus.bvalid !== 1'b0) begin errors++;
            $display("FAIL lead_early got led=%h bv=%b exp %h/0", led, bus.bvalid, m_led_out); end
        bus.wdata = {24'h0, nv}; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick(); bus.wvalid = 1'b0;
        m_led_out = nv;
        checks++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || led !== nv) begin errors++;
            $display("FAIL lead_done got bv=%b resp=%b led=%h exp 1/00/%h", bus.bvalid, bus.bresp, led, nv); end
        bus.bready = 1'b1; tick(); bus.bready = 1'b0;
        checks++; if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL lead_bdrop got %b exp 0", bus.bvalid); end
    endtask

    task automatic test_rw_same_cycle();
        logic [7:0] old, nv;
        old = m_led_out; nv = m_led_out + 8'h33;
        bus.awaddr = 9'h00; bus.wdata = {24'h0, nv}; bus.wstrb = 4'hF; bus.araddr = 9'h00;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        m_led_out = nv;
        checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== {24'h0, old}) begin errors++;
            $display("FAIL rw_old got rv=%b d=%h exp 1/%h", bus.rvalid, bus.rdata, old); end
        checks++; if (bus.bvalid !== 1'b1 || led !== nv) begin errors++;
            $display("FAIL rw_new got bv=%b led=%h exp 1/%h", bus.bvalid, led, nv); end
        bus.rready = 1'b1; bus.bready = 1'b1; tick(); bus.rready = 1'b0; bus.bready = 1'b0;
    endtask

`ifdef AXIL_LED_BLINK_EN
    task automatic test_blink();
        logic [1:0] r; logic bv, rv; logic [WIRQ-1:0] rq; logic [31:0] d;
        logic [7:0] lo, mk, exp_led; int p;
        axi_write(9'h00, 32'h0, 4'hF, r, bv, rq); m_led_out = 8'h00;
        axi_write(9'h04, 32'h0F, 4'hF, r, bv, rq);
        axi_write(9'h08, 32'd4, 4'hF, r, bv, rq);
        for (int k = 0; k < 16; k++) begin
            exp_led = (((k + 1) / 4) % 2 == 1) ? 8'h0F : 8'h00;
            checks++; if (led !== exp_led) begin errors++; $display("FAIL blink4 k%0d got %h exp %h", k, led, exp_led); end
            tick();
        end
        axi_read(9'h04, d, r, rv);
        checks++; if (d !== 32'h0F) begin errors++; $display("FAIL blink_mask_rd got %h exp 0f", d); end
        axi_read(9'h08, d, r, rv);
        checks++; if (d !== 32'd4) begin errors++; $display("FAIL blink_per_rd got %h exp 4", d); end
        axi_write(9'h08, 32'h0, 4'hF, r, bv, rq);
        for (int k = 0; k < 10; k++) begin
            checks++; if (led !== 8'h00) begin errors++; $display("FAIL blink_stop k%0d got %h exp 00", k, led); end
            tick();
        end
        axi_write(9'h08, 32'h12345678, 4'b0101, r, bv, rq);
        axi_read(9'h08, d, r, rv);
        checks++; if (d !== 32'h00340078) begin errors++; $display("FAIL blink_per_strb got %h exp 00340078", d); end
        for (int it = 0; it < 3; it++) begin
            lo = 8'($urandom); mk = 8'($urandom); p = $urandom_range(1, 5);
            axi_write(9'h00, {24'h0, lo}, 4'hF, r, bv, rq); m_led_out = lo;
            axi_write(9'h04, {24'h0, mk}, 4'hF, r, bv, rq);
            axi_write(9'h08, p, 4'hF, r, bv, rq);
            for (int k = 0; k < 12; k++) begin
                exp_led = (((k + 1) / p) % 2 == 1) ? (lo ^ mk) : lo;
                checks++; if (led !== exp_led) begin errors++;
                    $display("FAIL blink_rand it%0d p%0d k%0d got %h exp %h", it, p, k, led, exp_led); end
                tick();
            end
        end
        axi_write(9'h08, 32'h0, 4'hF, r, bv, rq);
        axi_write(9'h04, 32'h0, 4'hF, r, bv, rq);
    endtask
`else
    task automatic test_no_blink();
        logic [1:0] r; logic bv, rv; logic [WIRQ-1:0] rq; logic [31:0] d;
        axi_write(9'h04, 32'hFF, 4'hF, r, bv, rq);
        checks++; if (bv !== 1'b1 || r !== 2'b00) begin errors++; $display("FAIL nb_mask_wr got bv=%b r=%b exp 1/00", bv, r); end
        axi_write(9'h08, 32'd3, 4'hF, r, bv, rq);
        checks++; if (bv !== 1'b1 || r !== 2'b00) begin errors++; $display("FAIL nb_per_wr got bv=%b r=%b exp 1/00", bv, r); end
        axi_read(9'h04, d, r, rv);
        checks++; if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL nb_mask_rd got %h/%b exp 0/00", d, r); end
        axi_read(9'h08, d, r, rv);
        checks++; if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL nb_per_rd got %h/%b exp 0/00", d, r); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (led !== m_led_out) begin errors++; $display("FAIL nb_led k%0d got %h exp %h", k, led, m_led_out); end
            tick();
        end
    endtask
`endif

    task automatic test_irq_sequence();
        logic [1:0] r; logic bv, rv; logic [WIRQ-1:0] rq; logic [31:0] d;
        axi_write(9'h0C, 32'h1, 4'hF, r, bv, rq);
        checks++; if (rq[0] !== 1'b0) begin errors++; $display("FAIL irq_lat_early got %b exp 0", rq[0]); end
        checks++; if (req[0] !== 1'b1) begin errors++; $display("FAIL irq_lat_req got %b exp 1", req[0]); end
        axi_write(9'h0C, 32'h1, 4'hF, r, bv, rq);
        axi_read(9'h10, d, r, rv);
        checks++; if (d !== 32'h00010001) begin errors++; $display("FAIL irq_status_pend got %h exp 00010001", d); end
        ack = 2'b01; tick(); ack = '0;
        checks++; if (req[0] !== 1'b0) begin errors++; $display("FAIL irq_ack_drop got %b exp 0", req[0]); end
        tick();
        checks++; if (req[0] !== 1'b1) begin errors++; $display("FAIL irq_rereq got %b exp 1", req[0]); end
        ack = 2'b01; tick(); ack = '0;
        m_cnt = m_cnt + 32'd2;
        axi_read(9'h14, d, r, rv);
        checks++; if (d !== m_cnt) begin errors++; $display("FAIL irq_count got %0d exp %0d", d, m_cnt); end
        axi_read(9'h10, d, r, rv);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL irq_status_idle got %h exp 0", d); end
    endtask

    task automatic test_irq_dual_ack();
        logic [1:0] r; logic bv, rv; logic [WIRQ-1:0] rq; logic [31:0] d;
        axi_write(9'h0C, 32'h3, 4'hF, r, bv, rq);
        tick();
        checks++; if (req !== 2'b11) begin errors++; $display("FAIL dual_req got %b exp 11", req); end
        ack = 2'b11; tick(); ack = '0;
        checks++; if (req !== 2'b00) begin errors++; $display("FAIL dual_drop got %b exp 00", req); end
        m_cnt = m_cnt + 32'd2;
        axi_read(9'h14, d, r, rv);
        checks++; if (d !== m_cnt) begin errors++; $display("FAIL dual_count got %0d exp %0d", d, m_cnt); end
    endtask

    task automatic test_irq_random();
        logic [1:0] r; logic bv, rv; logic [WIRQ-1:0] rq, mask; logic [31:0] d, data, exp_st; logic [3:0] strb;
        m_req = '0; m_pend = '0;
        for (int it = 0; it < 14; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom; strb = 4'($urandom_range(0, 15));
                axi_write(9'h0C, data, strb, r, bv, rq);
                if (strb[0]) m_pend = m_pend | data[WIRQ-1:0];
                m_settle();
            end else begin
                mask = WIRQ'($urandom_range(0, 3));
                ack = mask; tick(); ack = '0;
                m_cnt = m_cnt + 32'($countones(mask & m_req));
                m_req = m_req & ~mask;
                m_settle();
            end
            repeat (2) tick();
            checks++; if (req !== m_req) begin errors++; $display("FAIL irq_rand_req it%0d got %b exp %b", it, req, m_req); end
            exp_st = {14'h0, m_pend, 14'h0, m_req};
            axi_read(9'h10, d, r, rv);
            checks++; if (d !== exp_st) begin errors++; $display("FAIL irq_rand_status it%0d got %h exp %h", it, d, exp_st); end
            axi_read(9'h14, d, r, rv);
            checks++; if (d !== m_cnt) begin errors++; $display("FAIL irq_rand_count it%0d got %0d exp %0d", it, d, m_cnt); end
        end
        ack = m_req; tick(); ack = '0;
        m_cnt = m_cnt + 32'($countones(m_req));
        m_req = '0; m_settle();
        repeat (3) tick();
        ack = m_req; tick(); ack = '0;
        m_cnt = m_cnt + 32'($countones(m_req));
        m_req = '0;
    endtask

    task automatic test_unmapped();
        logic [1:0] r; logic bv, rv; logic [WIRQ-1:0] rq; logic [31:0] d;
        axi_read(9'h18, d, r, rv);
        checks++; if (rv !== 1'b1 || r !== 2'b10 || d !== 32'h0) begin errors++;
            $display("FAIL unmap_rd18 got rv=%b r=%b d=%h exp 1/10/0", rv, r, d); end
        axi_read(9'h1C, d, r, rv);
        checks++; if (r !== 2'b10 || d !== 32'h0) begin errors++; $display("FAIL unmap_rd1c got r=%b d=%h exp 10/0", r, d); end
        axi_write(9'h1C, 32'hFFFFFFFF, 4'hF, r, bv, rq);
        checks++; if (bv !== 1'b1 || r !== 2'b10) begin errors++; $display("FAIL unmap_wr got bv=%b r=%b exp 1/10", bv, r); end
        axi_write(9'h14, 32'hFFFFFFFF, 4'hF, r, bv, rq);
        checks++; if (bv !== 1'b1 || r !== 2'b00) begin errors++; $display("FAIL ro_wr got bv=%b r=%b exp 1/00", bv, r); end
        axi_read(9'h14, d, r, rv);
        checks++; if (d !== m_cnt) begin errors++; $display("FAIL ro_count got %0d exp %0d", d, m_cnt); end
        axi_read(9'h0C, d, r, rv);
        checks++; if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL trig_rd got %h/%b exp 0/00", d, r); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] r; logic bv, rv; logic [WIRQ-1:0] rq; logic [31:0] d;
        axi_write(9'h0C, 32'h2, 4'hF, r, bv, rq);
        tick();
        checks++; if (req !== 2'b10) begin errors++; $display("FAIL mid_pre_req got %b exp 10", req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (req !== 2'b00 || led !== 8'h00) begin errors++;
            $display("FAIL mid_async got req=%b led=%h exp 00/00", req, led); end
        tick();
        rst_n = 1'b1;
        tick();
        m_led_out = '0; m_cnt = '0; m_req = '0; m_pend = '0;
        for (int a = 0; a < 6; a++) begin
            axi_read(9'(a * 4), d, r, rv);
            checks++; if (rv !== 1'b1 || d !== 32'h0) begin errors++;
                $display("FAIL mid_reg%0d got rv=%b d=%h exp 1/0", a, rv, d); end
        end
    endtask

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        ack = '0;
        m_led_out = '0; m_cnt = '0; m_req = '0; m_pend = '0;
        test_reset();
        test_led_basic();
        test_led_random();
        test_aw_lead();
        test_rw_same_cycle();
`ifdef AXIL_LED_BLINK_EN
        test_blink();
`else
        test_no_blink();
`endif
        test_irq_sequence();
        test_irq_dual_ack();
        test_irq_random();
        test_unmapped();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axil_led_irq_ctrl.md
# axil_led_irq_ctrl

AXI4-Lite register slave that drives the board LED bank and generates XDMA user interrupts, hanging off the XDMA `m_axil_*` master port. It provides static LED control and hardware blink on top of it. It also provides software-triggered interrupt requests that follow the XDMA `usr_irq_req`/`usr_irq_ack` handshake. It feeds `LED` and `usr_irq_req` directly into the XDMA top.

## Interface
Parameters:
- `WIRQ`, 2, number of user interrupt lines (1..16).
- `ADDR_WIDTH`, 9, AXI-Lite address width; only `addr[4:2]` are decoded.
- `CNT_WIDTH`, 32, blink counter width (8..32).

Ports (clock `axi_aclk`, reset `axi_aresetn`; one clock; reset is asynchronous and active-low):
- `axi_aclk` in 1: sole clock.
- `axi_aresetn` in 1: asynchronous active-low reset.
- `s_axil_awaddr` in ADDR_WIDTH, `s_axil_awvalid` in 1, `s_axil_awready` out 1: write address channel.
- `s_axil_wdata` in 32, `s_axil_wstrb` in 4, `s_axil_wvalid` in 1, `s_axil_wready` out 1: write data channel.
- `s_axil_bresp` out 2, `s_axil_bvalid` out 1, `s_axil_bready` in 1: write response channel.
- `s_axil_araddr` in ADDR_WIDTH, `s_axil_arvalid` in 1, `s_axil_arready` out 1: read address channel.
- `s_axil_rdata` out 32, `s_axil_rresp` out 2, `s_axil_rvalid` out 1, `s_axil_rready` in 1: read data channel.
- `led` out 8: LED drive.
- `usr_irq_req` out WIRQ: to XDMA, held per line until acknowledged.
- `usr_irq_ack` in WIRQ: from XDMA, one-cycle acknowledge per line.

## Operation
- Register map (byte offsets):
  - 0x00 LED_OUT RW [7:0].
  - 0x04 BLINK_MASK RW [7:0].
  - 0x08 BLINK_PERIOD RW [CNT_WIDTH-1:0].
  - 0x0C IRQ_TRIG W1S [WIRQ-1:0]; reads 0.
  - 0x10 IRQ_STATUS RO: {pending[WIRQ-1:0] at [31:16], req[WIRQ-1:0] at [15:0]}.
  - 0x14 IRQ_COUNT RO, 32-bit, wraps at 2^32.
  - 0x18–0x1C unmapped: reads return 0, responses SLVERR (2'b10). Writes to RO registers are ignored with OKAY.
- RW registers honour `wstrb` per byte. IRQ_TRIG is acted on only if `wstrb[0]` (and `wstrb[1]` for bits 15:8).
- LED output: `led = LED_OUT ^ (BLINK_MASK & {8{phase}})`.
- Blink: counter runs 0..BLINK_PERIOD-1. At terminal count, phase toggles and the counter clears. BLINK_PERIOD=0 stops the counter and forces phase=0. Any write to BLINK_PERIOD clears the counter and phase.
- IRQ, per line i, two states:
  - IDLE: if pending[i], go to REQ and clear pending[i].
  - REQ: `usr_irq_req[i]`=1. On `usr_irq_ack[i]`=1, go to IDLE and increment IRQ_COUNT.
- A trigger while in REQ sets pending[i]. The line re-requests after at least one IDLE cycle with `usr_irq_req[i]`=0.
- `usr_irq_ack[i]` seen in IDLE is ignored.
- Simultaneous acks on multiple lines add their popcount to IRQ_COUNT in one cycle.

## Timing
- Reset values: all registers 0, phase 0, every IRQ line IDLE. Outputs: `led`=0, `usr_irq_req`=0, `awready`=`wready`=`arready`=0 until the first cycle after reset release, `bvalid`=`rvalid`=0, `bresp`=`rresp`=0, `rdata`=0.
- Write path: AW and W are accepted independently. Each ready is high while its channel is not yet captured and `bvalid`=0. Once both are captured at edge N, the register updates and `bvalid` asserts at N+1. `bvalid` holds until `bready`. Only one write is outstanding at a time.
- Read path: `arready` = !`rvalid`. A handshake at edge N gives `rvalid`/`rdata` at N+1, held stable until `rready`.
- A read and a write to the same register in the same cycle: the read returns the old value.
- IRQ_TRIG write completing at edge N → `usr_irq_req[i]`=1 from N+2 (pending at N+1).
- Ack at edge N → `usr_irq_req[i]`=0 from N+1, and IRQ_COUNT updated at N+1.
- Reset asserted mid-operation aborts in-flight AXI transactions and drops `usr_irq_req` asynchronously.

## Configuration
- `AXIL_LED_BLINK_EN` defined: blink counter, BLINK_MASK and BLINK_PERIOD are implemented as above.
- Not defined: no counter logic. 0x04/0x08 read 0; writes to them are ignored with OKAY response. `led = LED_OUT`.

## Test plan
- Write 0x000000A5 to 0x00 with wstrb=4'hF → `bvalid` 1 cycle after the AW/W handshake, `bresp`=0, `led`=8'hA5; read 0x00 returns 0xA5.
- AW presented 3 cycles before W → single response, `bresp`=0, register updated only after W accepted.
- LED_OUT=0, BLINK_MASK=0x0F, BLINK_PERIOD=4 (macro defined) → `led` alternates 0x00/0x0F every 4 cycles; writing BLINK_PERIOD=0 → `led`=0x00 steady.
- Write IRQ_TRIG=1 → `usr_irq_req[0]`=1 two cycles later. A second trigger before the ack → IRQ_STATUS=0x00010001. Ack → req drops for ≥1 cycle, then reasserts. After the second ack, IRQ_COUNT=2.
- Both lines in REQ, `usr_irq_ack`=2'b11 in the same cycle → both requests drop, IRQ_COUNT increases by 2.
- Read 0x18 → `rresp`=2'b10, `rdata`=0. Assert `axi_aresetn`=0 while `usr_irq_req`=1 → req=0 immediately, all registers 0.
